// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 4 lines of 128 bits.
// Hits complete combinationally; misses stall through EVICT/FILL/DONE.
module data_cache (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_read,
    input  logic         req_write,
    input  logic         req_byte,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic [31:0]  rdata,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ack
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EVICT,
        S_FILL,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_valid;
    logic [3:0]   r_dirty;
    logic         r_ack_gap;

    logic [25:0]  w_tags  [4];
    logic [127:0] w_lines [4];

    logic [3:0]   w_offset;
    logic [1:0]   w_index;
    logic [25:0]  w_tag;
    logic [25:0]  w_cur_tag;
    logic [127:0] w_cur_line;
    logic [127:0] w_merged;
    logic         w_req;
    logic         w_is_read;
    logic         w_hit;
    logic         w_hit_we;
    logic         w_fill_we;
    logic         w_evict_done;
    logic         w_ack;
    logic         w_stall;

    assign w_offset   = req_addr[3:0];
    assign w_index    = req_addr[5:4];
    assign w_tag      = req_addr[31:6];
    assign w_cur_tag  = w_tags[w_index];
    assign w_cur_line = w_lines[w_index];

    // A simultaneous read and write is a write.
    assign w_req     = req_read | req_write;
    assign w_is_read = req_read & ~req_write;
    assign w_hit     = w_req & r_valid[w_index] & (w_cur_tag == w_tag);
    assign w_hit_we  = (r_state == S_IDLE) & req_write & w_hit;

    // The ack that ends an eviction must not also complete the fill behind it.
    assign w_ack = mem_ack & ~r_ack_gap;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_line
            logic [127:0] r_line;
            logic [25:0]  r_tag;
            logic         w_sel;

            assign w_sel = (w_index == 2'(gi));

            always_ff @(posedge clock) begin
                if (w_fill_we && w_sel) begin
                    r_line <= mem_rdata;
                    r_tag  <= w_tag;
                end else if (w_hit_we && w_sel) begin
                    r_line <= w_merged;
                end
            end

            assign w_lines[gi] = r_line;
            assign w_tags[gi]  = r_tag;
        end
    endgenerate

    always_comb begin
        w_merged = w_cur_line;
        if (req_byte) begin
            w_merged[{w_offset, 3'b000} +: 8] = req_wdata[7:0];
        end else begin
            w_merged[{w_offset[3:2], 5'b00000} +: 32] = req_wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if ((r_state == S_IDLE) && w_is_read && w_hit) begin
            if (req_byte) begin
                rdata = {24'd0, w_cur_line[{w_offset, 3'b000} +: 8]};
            end else begin
                rdata = w_cur_line[{w_offset[3:2], 5'b00000} +: 32];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_fill_we    = 1'b0;
        w_evict_done = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    w_stall = 1'b1;
                    if (r_valid[w_index] && r_dirty[w_index]) begin
                        w_state_next = S_EVICT;
                    end else begin
                        w_state_next = S_FILL;
                    end
                end
            end
            S_EVICT: begin
                w_stall   = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {w_cur_tag, w_index, 4'b0000};
                mem_wdata = w_cur_line;
                if (w_ack) begin
                    w_evict_done = 1'b1;
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                w_stall  = 1'b1;
                mem_req  = ~r_ack_gap;
                mem_addr = {w_tag, w_index, 4'b0000};
                if (w_ack) begin
                    w_fill_we    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_stall      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign stall = w_stall & ~reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            r_dirty   <= '0;
            r_ack_gap <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ack_gap <= w_evict_done;
            if (w_evict_done) begin
                r_dirty[w_index] <= 1'b0;
            end
            if (w_fill_we) begin
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end
            if (w_hit_we) begin
                r_dirty[w_index] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: vector table plus hand-written miss,
// delayed-ack and reset-during-fill sequences, with a backing-memory scoreboard.
module tb_data_cache;
    logic         clock = 1'b0;
    logic         reset;
    logic         req_read;
    logic         req_write;
    logic         req_byte;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [31:0]  rdata;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;

    data_cache dut (
        .clock     (clock),
        .reset     (reset),
        .req_read  (req_read),
        .req_write (req_write),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } memexp_t;

    typedef struct packed {
        logic         rd;
        logic         wr;
        logic         bt;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic         miss;
        logic         evict;
        logic [31:0]  ev_addr;
        logic [127:0] ev_data;
        logic [31:0]  exp_rdata;
    } vec_t;

    memexp_t      exp_q[$];
    vec_t         vt[14];
    logic [127:0] mem_model [logic [31:0]];
    int           n_tests = 0;
    int           n_fail = 0;
    int           ack_delay = 0;
    bit           resp_en = 1'b1;

    function automatic logic [127:0] dflt(input logic [31:0] a);
        return {a ^ 32'h11111111, a ^ 32'h22222222, a ^ 32'h33333333, a ^ 32'h44444444};
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic bt,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic miss, input logic evict,
                                input logic [31:0] ev_addr, input logic [127:0] ev_data,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.rd = rd;
        v.wr = wr;
        v.bt = bt;
        v.addr = addr;
        v.wdata = wdata;
        v.miss = miss;
        v.evict = evict;
        v.ev_addr = ev_addr;
        v.ev_data = ev_data;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Backing memory: pops the expected transfer, checks it, then acks.
    initial begin : responder
        logic [31:0] a;
        logic        w;
        memexp_t     e;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (resp_en && mem_req) begin
                a = mem_addr;
                w = mem_we;
                chk("mem_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("mem_we", 128'(mem_we), 128'(e.we));
                    chk("mem_addr", 128'(mem_addr), 128'(e.addr));
                    if (e.we) begin
                        chk("mem_wdata", mem_wdata, e.wdata);
                    end
                end
                for (int d = 0; d < ack_delay; d++) begin
                    @(negedge clock);
                    chk("hold_req", 128'(mem_req), 128'(1));
                    chk("hold_addr", 128'(mem_addr), 128'(a));
                    chk("hold_stall", 128'(stall), 128'(1));
                    chk("hold_rdata", 128'(rdata), 128'(0));
                end
                mem_rdata = w ? 128'd0 : (mem_model.exists(a) ? mem_model[a] : dflt(a));
                if (w) begin
                    mem_model[a] = mem_wdata;
                end
                mem_ack = 1'b1;
                @(negedge clock);
                mem_ack   = 1'b0;
                mem_rdata = '0;
                chk("req_drop_after_ack", 128'(mem_req), 128'(0));
                $display("[TB] mem %s addr=%08h", w ? "writeback" : "fill", a);
            end
        end
    end

    task automatic access(input vec_t v, input string name);
        int      cyc;
        memexp_t e;
        if (v.miss) begin
            if (v.evict) begin
                e.we = 1'b1;
                e.addr = v.ev_addr;
                e.wdata = v.ev_data;
                exp_q.push_back(e);
            end
            e.we = 1'b0;
            e.addr = {v.addr[31:4], 4'b0000};
            e.wdata = '0;
            exp_q.push_back(e);
        end
        req_read  = v.rd;
        req_write = v.wr;
        req_byte  = v.bt;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clock);
        chk({name, "_stall_first"}, 128'(stall), 128'(v.miss));
        cyc = 0;
        while (stall && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk({name, "_stall_release"}, 128'(cyc < 200), 128'(1));
        chk({name, "_rdata"}, 128'(rdata), 128'(v.exp_rdata));
        $display("[TB] %s addr=%08h rd=%0b wr=%0b byte=%0b rdata=%08h stall_cycles=%0d",
                 name, v.addr, v.rd, v.wr, v.bt, rdata, cyc);
        @(posedge clock);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        reset     = 1'b1;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_model[32'h40] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

        vt[0]  = mk(1, 0, 0, 32'h40, 32'h0,        1, 0, 32'h0,  128'h0, 32'hAAAAAAAA);
        vt[1]  = mk(0, 1, 1, 32'h43, 32'h5A,       0, 0, 32'h0,  128'h0, 32'h0);
        vt[2]  = mk(1, 0, 1, 32'h43, 32'h0,        0, 0, 32'h0,  128'h0, 32'h5A);
        vt[3]  = mk(1, 0, 0, 32'h40, 32'h0,        0, 0, 32'h0,  128'h0, 32'h5AAAAAAA);
        vt[4]  = mk(1, 1, 0, 32'h44, 32'h12345678, 0, 0, 32'h0,  128'h0, 32'h0);
        vt[5]  = mk(1, 0, 0, 32'h44, 32'h0,        0, 0, 32'h0,  128'h0, 32'h12345678);
        vt[6]  = mk(1, 0, 1, 32'h45, 32'h0,        0, 0, 32'h0,  128'h0, 32'h56);
        vt[7]  = mk(1, 0, 0, 32'h4F, 32'h0,        0, 0, 32'h0,  128'h0, 32'hDDDDDDDD);
        vt[8]  = mk(1, 0, 0, 32'h80, 32'h0,        1, 1, 32'h40,
                    128'hDDDDDDDD_CCCCCCCC_12345678_5AAAAAAA, 32'h444444C4);
        vt[9]  = mk(1, 0, 0, 32'h40, 32'h0,        1, 0, 32'h0,  128'h0, 32'h5AAAAAAA);
        vt[10] = mk(0, 1, 0, 32'h50, 32'hCAFEF00D, 1, 0, 32'h0,  128'h0, 32'h0);
        vt[11] = mk(1, 0, 0, 32'h50, 32'h0,        0, 0, 32'h0,  128'h0, 32'hCAFEF00D);
        vt[12] = mk(1, 0, 1, 32'h52, 32'h0,        0, 0, 32'h0,  128'h0, 32'hFE);
        vt[13] = mk(1, 0, 0, 32'h90, 32'h0,        1, 1, 32'h50,
                    128'h11111141_22222272_33333363_CAFEF00D, 32'h444444D4);

        repeat (2) @(negedge clock);
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_mem_req", 128'(mem_req), 128'(0));
        chk("rst_mem_we", 128'(mem_we), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", mem_wdata, 128'(0));
        chk("rst_rdata", 128'(rdata), 128'(0));
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 14; i++) begin
            access(vt[i], $sformatf("vec%0d", i));
        end

        // Slow memory: request and address must hold while stalled.
        ack_delay = 5;
        access(mk(1, 0, 0, 32'hE0, 32'h0, 1, 0, 32'h0, 128'h0, 32'h444444A4), "slow_ack");
        ack_delay = 0;

        // Reset in the middle of a fill drops the request at once.
        resp_en  = 1'b0;
        req_read = 1'b1;
        req_addr = 32'hC0;
        @(negedge clock);
        chk("rstfill_stall", 128'(stall), 128'(1));
        cyc = 0;
        while (!mem_req && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk("rstfill_req", 128'(mem_req), 128'(1));
        chk("rstfill_addr", 128'(mem_addr), 128'(32'hC0));
        chk("rstfill_we", 128'(mem_we), 128'(0));
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("rstfill_req_drop", 128'(mem_req), 128'(0));
        chk("rstfill_stall_drop", 128'(stall), 128'(0));
        chk("rstfill_addr_zero", 128'(mem_addr), 128'(0));
        $display("[TB] reset asserted during fill of addr=000000c0");
        req_read = 1'b0;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        resp_en = 1'b1;

        access(mk(1, 0, 0, 32'h40, 32'h0, 1, 0, 32'h0, 128'h0, 32'h5AAAAAAA), "post_rst_40");
        access(mk(1, 0, 0, 32'hE0, 32'h0, 1, 0, 32'h0, 128'h0, 32'h444444A4), "post_rst_E0");

        // No request presented: rdata stays zero even on a resident line.
        req_addr = 32'h40;
        @(negedge clock);
        chk("idle_rdata", 128'(rdata), 128'(0));
        chk("idle_stall", 128'(stall), 128'(0));
        $display("[TB] idle addr=00000040 rdata=%08h stall=%0b", rdata, stall);

        @(negedge clock);
        chk("mem_queue_drained", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: req_read  in  1  load request from execute/memory stage.
REQ-004 SHALL have: req_write  in  1  store request; req_read and req_write both high treated as write.
REQ-005 SHALL have: req_byte  in  1  1 = byte access, 0 = word access.
REQ-006 SHALL have: req_addr  in  32  byte address; word accesses ignore bits [1:0].
REQ-007 SHALL have: req_wdata  in  32  store data; byte stores use bits [7:0].
REQ-008 SHALL have: rdata  out  32  load result, zero-extended for bytes.
REQ-009 SHALL have: stall  out  1  pipeline hold; request must stay stable while high.
REQ-010 SHALL have: mem_req  out  1  backing-memory request, held until mem_ack.
REQ-011 SHALL have: mem_we  out  1  1 = line write-back, 0 = line fill.
REQ-012 SHALL have: mem_addr  out  32  line address, bits [3:0] = 0.
REQ-013 SHALL have: mem_wdata  out  128  evicted line data.
REQ-014 SHALL have: mem_rdata  in  128  fill data, valid with mem_ack.
REQ-015 SHALL have: mem_ack  in  1  single-cycle completion pulse.

Function
REQ-016 SHALL be direct-mapped, 4 lines x 128 bits, write-back, write-allocate; offset [3:0], index [5:4], tag [31:6]; per line valid, dirty, 26-bit tag.
REQ-017 SHALL hit when valid[index] and tag match; hit read drives rdata combinationally same cycle, stall = 0.
REQ-018 SHALL on hit write update the selected word/byte and set dirty at the next rising edge, stall = 0.
REQ-019 SHALL drive rdata = 0 when no read hit is presented.
REQ-020 SHALL implement FSM IDLE, EVICT, FILL, DONE.
REQ-021 SHALL on miss in IDLE: stall = 1 same cycle; go to EVICT if victim valid and dirty, else FILL.
REQ-022 SHALL in EVICT assert mem_req=1, mem_we=1, mem_addr={victim tag,index,4'b0}, mem_wdata=victim line; on mem_ack clear dirty, go to FILL.
REQ-023 SHALL in FILL assert mem_req=1, mem_we=0, mem_addr={req tag,index,4'b0}; on mem_ack write line, set valid, dirty=0, tag; go to DONE.
REQ-024 SHALL in DONE keep stall = 1 one cycle, return to IDLE; request then re-evaluates as hit (write hit sets dirty). Miss latency = handshake cycles + 1.
REQ-025 SHALL deassert mem_req in the cycle after mem_ack; never issue a new request in the ack cycle.
REQ-026 SHALL keep stall = 1 in EVICT, FILL, DONE regardless of request inputs.
REQ-027 SHALL ignore mem_ack outside EVICT/FILL.
REQ-028 SHALL, byte access: lane = addr[3:0]; word access: word = addr[3:2].

Reset
REQ-029 SHALL on reset clear all valid and dirty bits, FSM to IDLE; outputs stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.
REQ-030 SHALL on reset mid-EVICT/FILL abandon the transfer; dirty data lost, no partial line written.

Verification
REQ-031 SHALL cover: after reset, read 0x00000040, fill ack data 0x...DDDDCCCCBBBBAAAA -> stall 1 until DONE, mem_addr 0x40, mem_we 0, then rdata 0xAAAAAAAA, stall 0.
REQ-032 SHALL cover: byte write 0x5A to 0x00000043 on hit, then byte read 0x43 -> rdata 0x0000005A; word read 0x40 -> 0x5AAAAAAA.
REQ-033 SHALL cover: dirty line tag 0x1, access 0x00000080 same index -> EVICT mem_we 1, mem_addr 0x40, mem_wdata old line, then FILL mem_addr 0x80.
REQ-034 SHALL cover: mem_ack delayed 5 cycles -> mem_req and mem_addr stable throughout, stall held, rdata 0.
REQ-035 SHALL cover: reset asserted during FILL -> mem_req 0 immediately; next read 0x40 misses again.
REQ-036 SHALL cover: req_read and req_write both high on hit 0x44, wdata 0x12345678 -> treated as write; read 0x44 returns 0x12345678.
